nbit_reg: RTL and testbench

NBIT_REG -- requirements
Module: nbit_reg

---
 rtl/nbit_reg.sv | 46 ++++
 tb/tb_nbit_reg.sv | 115 +++++++++++
 2 files changed

// File: rtl/nbit_reg.sv
// nbit_reg: n-bit register with synchronous active-high reset, local and global write enables.
// Define NBIT_REG_XCHECK_EN to compile a simulation-only X/Z check on the inputs.
module nbit_reg #(
  parameter int n = 1,
  parameter     r = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         gwe,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  // Truncate a wide r and zero-extend a narrow one, even when r is a signed literal.
  localparam logic [n-1:0] reset_val = n'($unsigned(r));

  // NOTE: the declaration initialiser gives the flops their value from time zero,
  // before any reset; FPGA flows map it to the power-up state.
  logic [n-1:0] q = reset_val;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      q <= reset_val;
    else if (we && gwe)
      q <= in;
  end

  assign out = q;

`ifdef NBIT_REG_XCHECK_EN
`ifndef SYNTHESIS
  // Observation only: never feeds q.
  always @(posedge clk) begin
    if ($isunknown({rst, we, gwe}))
      $error("%m: X/Z on rst/we/gwe at time %0t", $time);
    if (rst === 1'b0 && we === 1'b1 && gwe === 1'b1 && $isunknown(in))
      $error("%m: X/Z on in during write at time %0t", $time);
  end
`endif
`else
  // Check disabled: the register above is the whole design.
`endif

endmodule

// File: tb/tb_nbit_reg.sv
// tb_nbit_reg: directed checks of nbit_reg at n=16 (r=0 and r=F00D), plus
// truncation (n=4) and zero-extension (n=20) of the reset value.
module tb_nbit_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic        gwe = 1'b0;
  logic [15:0] d_in = 16'h0000;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_t;
  logic [19:0] out_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nbit_reg #(.n(16), .r(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .we(we), .gwe(gwe), .in(d_in), .out(out_a));
  nbit_reg #(.n(16), .r(16'hF00D)) dut_b (
    .clk(clk), .rst(rst), .we(we), .gwe(gwe), .in(d_in), .out(out_b));
  nbit_reg #(.n(4), .r(8'hAB)) dut_t (
    .clk(clk), .rst(rst), .we(we), .gwe(gwe), .in(d_in[3:0]), .out(out_t));
  nbit_reg #(.n(20), .r(16'hF00D)) dut_w (
    .clk(clk), .rst(rst), .we(we), .gwe(gwe), .in({4'h0, d_in}), .out(out_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("init_a", 32'(out_a), 32'h0000);
    check("init_b", 32'(out_b), 32'hF00D);
    check("init_t", 32'(out_t), 32'h000B);
    check("init_w", 32'(out_w), 32'h0F00D);

    // Scenario 1: reset wins over an active write.
    rst = 1'b1; we = 1'b1; gwe = 1'b1; d_in = 16'hBEEF;
    step();
    check("rst_a", 32'(out_a), 32'h0000);
    check("rst_b", 32'(out_b), 32'hF00D);
    check("rst_t", 32'(out_t), 32'h000B);
    check("rst_w", 32'(out_w), 32'h0F00D);

    // Scenario 2: capture, then hold with we=0.
    rst = 1'b0; d_in = 16'h1234;
    step();
    check("wr_a", 32'(out_a), 32'h1234);
    check("wr_t", 32'(out_t), 32'h0004);
    check("wr_w", 32'(out_w), 32'h01234);
    d_in = 16'hABCD; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_we", 32'(out_a), 32'h1234);
    end

    // Scenario 3: gwe gates capture.
    we = 1'b1; gwe = 1'b0; d_in = 16'h5555;
    step();
    check("hold_gwe", 32'(out_a), 32'h1234);
    gwe = 1'b1;
    step();
    check("wr_gwe", 32'(out_a), 32'h5555);

    // Back-to-back writes, ending on 0001 which is then rewritten unchanged.
    d_in = 16'hA5A5; step(); check("b2b_0", 32'(out_a), 32'hA5A5);
    d_in = 16'h5A5A; step(); check("b2b_1", 32'(out_a), 32'h5A5A);
    d_in = 16'h0001; step(); check("b2b_2", 32'(out_b), 32'h0001);
    step();
    check("same_val", 32'(out_b), 32'h0001);

    // Scenario 4: mid-stream reset, then release with capture on the same edge.
    rst = 1'b1; d_in = 16'h7777;
    step();
    check("mid_rst_b", 32'(out_b), 32'hF00D);
    check("mid_rst_a", 32'(out_a), 32'h0000);
    rst = 1'b0;
    step();
    check("rel_b", 32'(out_b), 32'h7777);
    check("rel_a", 32'(out_a), 32'h7777);

    // Scenario 5: toggles between edges must not reach out.
    rst = 1'b1; #2;
    check("between_rst", 32'(out_b), 32'h7777);
    rst = 1'b0; d_in = 16'hAAAA; #2;
    check("between_in", 32'(out_b), 32'h7777);
    rst = 1'b1; #1;
    check("between_rst2", 32'(out_a), 32'h7777);
    rst = 1'b0; d_in = 16'h9999;
    step();
    check("edge_wr", 32'(out_b), 32'h9999);

    // Reset with both enables low still loads r.
    rst = 1'b1; we = 1'b0; gwe = 1'b0;
    step();
    check("rst_noen_b", 32'(out_b), 32'hF00D);
    check("rst_noen_t", 32'(out_t), 32'h000B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
